// File: rtl/inport_conditioner_if.sv
// Raw user-input levels in, conditioned in-port word and STOP indications out.
// The conditioner is the slave; whatever drives the raw pins and consumes the results is the master.
interface inport_conditioner_if;
    logic [7:0]  sw_raw;
    logic        stop_n_raw;
    logic [31:0] inport_data;
    logic        inport_changed;
    logic        stop_level;
    logic        stop_pulse;

    modport slave (
        input  sw_raw,
        input  stop_n_raw,
        output inport_data,
        output inport_changed,
        output stop_level,
        output stop_pulse
    );

    modport master (
        output sw_raw,
        output stop_n_raw,
        input  inport_data,
        input  inport_changed,
        input  stop_level,
        input  stop_pulse
    );
endinterface

// File: rtl/inport_conditioner.sv
// Synchronizes and debounces eight slide switches plus the active-low STOP key,
// producing a registered 32-bit in-port word and a single-cycle stop request.
module inport_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    inport_conditioner_if.slave   port
);

    // Channels 0..7 are the switches, channel 8 is the raw (active-low) STOP key.
    localparam int unsigned      NCH      = 9;
    localparam int unsigned      STOP_CH  = 8;
    localparam logic [NCH-1:0]   RST_VAL  = 9'h100;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync_1;
    logic [NCH-1:0]   sync_2;
    logic [NCH-1:0]   acc;
    logic [NCH-1:0]   acc_next;
    logic [CNT_W-1:0] cnt      [NCH];
    logic [CNT_W-1:0] cnt_next [NCH];

    logic             changed_q;
    logic             stop_level_q;
    logic             stop_pulse_q;

    assign raw = {port.stop_n_raw, port.sw_raw};

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= RST_VAL;
            sync_2 <= RST_VAL;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce: a differing synchronized level must persist for DEBOUNCE_CYCLES
    // consecutive edges; any return to the accepted value restarts the count.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        acc_next = acc;
        for (int i = 0; i < NCH; i++) begin
            cnt_next[i] = '0;
            if (sync_2[i] != acc[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    acc_next[i] = sync_2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the counter array is a bank of flops, not a RAM, so it is cleared by
    // reset like any other state; mid-count reset must restart debouncing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= RST_VAL;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            acc <= acc_next;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Strobes are derived from the same accept decision so they line up with
    // the accepted value they announce.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            changed_q    <= 1'b0;
            stop_level_q <= 1'b0;
            stop_pulse_q <= 1'b0;
        end else begin
            changed_q    <= |(acc_next[7:0] ^ acc[7:0]);
            stop_level_q <= ~acc_next[STOP_CH];
            stop_pulse_q <= acc[STOP_CH] & ~acc_next[STOP_CH];
        end
    end

    assign port.inport_data    = {24'b0, acc[7:0]};
    assign port.inport_changed = changed_q;
    assign port.stop_level     = stop_level_q;
    assign port.stop_pulse     = stop_pulse_q;

endmodule
